// File: rtl/tc0260dar_pkg.sv
// Shared types and helpers for the TC0260DAR palette block.
package tc0260dar_pkg;

  localparam int FMT_RGB555 = 0;  // xRRRRRGGGGGBBBBB
  localparam int FMT_RGB444 = 1;  // RRRRGGGGBBBBxxxx

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } cpu_state_t;

  // Widen a palette word to 8:8:8. Low bits are filled by replicating the
  // high bits so full-scale codes map to 0xFF.
  function automatic logic [23:0] expand_rgb(input logic [15:0] w, input logic fmt444);
    logic [4:0] r5, g5, b5;
    logic [3:0] r4, g4, b4;
    r5 = w[14:10];
    g5 = w[9:5];
    b5 = w[4:0];
    r4 = w[15:12];
    g4 = w[11:8];
    b4 = w[7:4];
    if (fmt444)
      return {r4, r4, g4, g4, b4, b4};
    return {r5, r5[4:2], g5, g5[4:2], b5, b5[4:2]};
  endfunction

endpackage

// File: rtl/tc0260dar_palette_dpram.sv
// True dual-port palette RAM. Port A: video read. Port B: CPU read/write
// with byte enables. Both reads are registered; a port-A read of a word
// being written on port B in the same clock returns the old contents.
module palette_dpram #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  output logic [15:0]           q_a,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [1:0]            be_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [15:0]           d_b,
  output logic [15:0]           q_b
);

  logic [15:0] mem [2**ADDR_WIDTH];

  // Video port: read every clock.
  always_ff @(posedge clk)
    q_a <= mem[addr_a];

  // CPU port: byte-lane writes, read-before-write data out.
  always_ff @(posedge clk) begin
    if (en_b) begin
      if (we_b && be_b[1]) mem[addr_b][15:8] <= d_b[15:8];
      if (we_b && be_b[0]) mem[addr_b][7:0]  <= d_b[7:0];
      q_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/tc0260dar_palette.sv
// TC0260DAR palette stage: colour index -> RGB through palette RAM, with a
// 68000-side RAM port and DTACK generation. Blanks ride the same pipeline.
module tc0260dar_palette
  import tc0260dar_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int RGB_FORMAT = FMT_RGB555
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce_pixel,
  input  logic [ADDR_WIDTH-1:0] VA,
  input  logic [15:0]           Din,
  output logic [15:0]           Dout,
  input  logic                  LDSn,
  input  logic                  UDSn,
  input  logic                  CSn,
  input  logic                  RW,
  output logic                  DACKn,
  input  logic [14:0]           SC,
  input  logic                  HBLOn,
  input  logic                  VBLOn,
  output logic [7:0]            R,
  output logic [7:0]            G,
  output logic [7:0]            B,
  output logic                  HBLn_out,
  output logic                  VBLn_out
);

  cpu_state_t            state, state_nxt;
  logic                  csn_q;
  logic                  cs_fall;
  logic [ADDR_WIDTH-1:0] va_q;
  logic [15:0]           din_q;
  logic                  lds_q, uds_q, rw_q;
  logic [15:0]           q_a, q_b;

  logic [ADDR_WIDTH-1:0] idx;
  logic                  hbl0, vbl0, hbl1, vbl1;
  logic [15:0]           colour;

  logic                  unused_sc;
  assign unused_sc = ^SC[14:ADDR_WIDTH];

  assign cs_fall = csn_q & ~CSn;

  // Previous CSn. Tracks through reset so a strobe held low across reset
  // does not look like a fresh falling edge afterwards.
  always_ff @(posedge clk)
    csn_q <= CSn;

  // CPU FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // CPU FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = ACCESS;
      ACCESS:  state_nxt = CSn ? IDLE : ACK;
      ACK:     if (CSn) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the bus cycle on the CS falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      va_q  <= '0;
      din_q <= '0;
      lds_q <= 1'b1;
      uds_q <= 1'b1;
      rw_q  <= 1'b1;
    end else if (state == IDLE && cs_fall) begin
      va_q  <= VA;
      din_q <= Din;
      lds_q <= LDSn;
      uds_q <= UDSn;
      rw_q  <= RW;
    end
  end

  // DTACK and read data: asserted while in ACK until CS is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      Dout  <= '0;
      DACKn <= 1'b1;
    end else if (state == ACK && !CSn) begin
      DACKn <= 1'b0;
      if (rw_q) Dout <= q_b;
    end else begin
      DACKn <= 1'b1;
    end
  end

  palette_dpram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk    (clk),
    .addr_a (idx),
    .q_a    (q_a),
    .en_b   (state == ACCESS),
    .we_b   (~rw_q),
    .be_b   ({~uds_q, ~lds_q}),
    .addr_b (va_q),
    .d_b    (din_q),
    .q_b    (q_b)
  );

  // Video pipeline: index/blank latch, colour word, expanded RGB.
  // The RAM word for idx is ready one clock after idx loads, so the next
  // ce_pixel captures it into colour.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      hbl0     <= 1'b0;
      vbl0     <= 1'b0;
      colour   <= '0;
      hbl1     <= 1'b0;
      vbl1     <= 1'b0;
      R        <= '0;
      G        <= '0;
      B        <= '0;
      HBLn_out <= 1'b0;
      VBLn_out <= 1'b0;
    end else if (ce_pixel) begin
      idx      <= SC[ADDR_WIDTH-1:0];
      hbl0     <= HBLOn;
      vbl0     <= VBLOn;
      colour   <= q_a;
      hbl1     <= hbl0;
      vbl1     <= vbl0;
      HBLn_out <= hbl1;
      VBLn_out <= vbl1;
      if (hbl1 && vbl1) {R, G, B} <= expand_rgb(colour, RGB_FORMAT == FMT_RGB444);
      else              {R, G, B} <= '0;
    end
  end

endmodule

// File: tb/tb_tc0260dar_palette.sv
// Directed bench for tc0260dar_palette: one RGB555 and one RGB444 instance
// share the same bus and video inputs.
module tb_tc0260dar_palette;

  logic        clk = 1'b0;
  logic        reset, ce_pixel;
  logic [11:0] VA;
  logic [15:0] Din;
  logic        LDSn, UDSn, CSn, RW;
  logic [14:0] SC;
  logic        HBLOn, VBLOn;

  logic [15:0] Dout, dout4;
  logic        DACKn, dackn4;
  logic [7:0]  R, G, B, r4, g4, b4;
  logic        HBLn_out, VBLn_out, hbl4, vbl4;

  tc0260dar_palette #(.ADDR_WIDTH(12), .RGB_FORMAT(0)) dut (
    .clk(clk), .reset(reset), .ce_pixel(ce_pixel), .VA(VA), .Din(Din),
    .Dout(Dout), .LDSn(LDSn), .UDSn(UDSn), .CSn(CSn), .RW(RW), .DACKn(DACKn),
    .SC(SC), .HBLOn(HBLOn), .VBLOn(VBLOn), .R(R), .G(G), .B(B),
    .HBLn_out(HBLn_out), .VBLn_out(VBLn_out)
  );

  tc0260dar_palette #(.ADDR_WIDTH(12), .RGB_FORMAT(1)) dut4 (
    .clk(clk), .reset(reset), .ce_pixel(ce_pixel), .VA(VA), .Din(Din),
    .Dout(dout4), .LDSn(LDSn), .UDSn(UDSn), .CSn(CSn), .RW(RW), .DACKn(dackn4),
    .SC(SC), .HBLOn(HBLOn), .VBLOn(VBLOn), .R(r4), .G(g4), .B(b4),
    .HBLn_out(hbl4), .VBLn_out(vbl4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] sc;
    logic [11:0] addr;
    logic [15:0] word;
    logic [23:0] exp555;
    logic [23:0] exp444;
  } vec_t;

  vec_t vecs[6];
  int   pass_cnt = 0;
  int   total    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One pixel period = two clocks, ce_pixel on the first.
  task automatic pix(input logic [14:0] sc, input logic h, input logic v);
    SC = sc; HBLOn = h; VBLOn = v;
    ce_pixel = 1'b1;
    tick;
    ce_pixel = 1'b0;
    tick;
  endtask

  task automatic cpu_start(input logic [11:0] a, input logic [15:0] d, input logic rw,
                           input logic uds, input logic lds, output int lat);
    VA = a; Din = d; RW = rw; UDSn = uds; LDSn = lds; CSn = 1'b0;
    lat = 0;
    while (DACKn !== 1'b0 && lat < 10) begin
      tick;
      lat++;
    end
    check("dack_assert", DACKn, 0);
  endtask

  task automatic cpu_end;
    CSn = 1'b1;
    tick;
    check("dack_release", DACKn, 1);
  endtask

  task automatic cpu_wr(input logic [11:0] a, input logic [15:0] d,
                        input logic uds, input logic lds);
    int lat;
    cpu_start(a, d, 1'b0, uds, lds, lat);
    cpu_end;
  endtask

  task automatic cpu_rd(input logic [11:0] a, output logic [15:0] q, output int lat);
    cpu_start(a, 16'h0000, 1'b1, 1'b0, 1'b0, lat);
    q = Dout;
    cpu_end;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] q;
    int          lat, cnt;
    logic        hs[7];
    logic        vs[7];

    reset = 1'b1; ce_pixel = 1'b0; CSn = 1'b1; RW = 1'b1; VA = '0; Din = '0;
    LDSn = 1'b1; UDSn = 1'b1; SC = '0; HBLOn = 1'b1; VBLOn = 1'b1;
    tick; tick; tick;
    check("reset_rgb",   {R, G, B}, 0);
    check("reset_dout",  Dout, 0);
    check("reset_dackn", DACKn, 1);
    check("reset_blank", {HBLn_out, VBLn_out}, 0);
    reset = 1'b0;
    tick;

    // sc, addr, word, RGB555 expectation, RGB444 expectation
    vecs[0] = '{15'h0005, 12'h005, 16'h7FFF, 24'hFFFFFF, 24'h77FFFF};
    vecs[1] = '{15'h0003, 12'h003, 16'hF80C, 24'hF70063, 24'hFF8800};
    vecs[2] = '{15'h0FFF, 12'hFFF, 16'h0000, 24'h000000, 24'h000000};
    vecs[3] = '{15'h0010, 12'h010, 16'h4210, 24'h848484, 24'h442211};
    vecs[4] = '{15'h0020, 12'h020, 16'h0421, 24'h080808, 24'h004422};
    vecs[5] = '{15'h600A, 12'h00A, 16'h03E0, 24'h00FF00, 24'h0033EE};

    for (int i = 0; i < 6; i++) begin
      cpu_wr(vecs[i].addr, vecs[i].word, 1'b0, 1'b0);
      pix(vecs[i].sc, 1'b1, 1'b1);
      pix(vecs[i].sc, 1'b1, 1'b1);
      pix(vecs[i].sc, 1'b1, 1'b1);
      check($sformatf("vec%0d_rgb555", i), {R, G, B}, vecs[i].exp555);
      check($sformatf("vec%0d_rgb444", i), {r4, g4, b4}, vecs[i].exp444);
    end

    // Read-back and DTACK latency (CS low -> DACKn low on the third edge).
    cpu_rd(12'h005, q, lat);
    check("rd5_data", q, 16'h7FFF);
    check("rd5_latency", lat, 3);

    // Byte lanes.
    cpu_wr(12'h009, 16'h1234, 1'b0, 1'b0);
    cpu_wr(12'h009, 16'hAB00, 1'b0, 1'b1);
    cpu_rd(12'h009, q, lat);
    check("byte_upper", q, 16'hAB34);
    cpu_wr(12'h009, 16'h00CD, 1'b1, 1'b0);
    cpu_rd(12'h009, q, lat);
    check("byte_lower", q, 16'hABCD);
    cpu_wr(12'h009, 16'hFFFF, 1'b1, 1'b1);
    cpu_rd(12'h009, q, lat);
    check("byte_none", q, 16'hABCD);

    // Blanking: single-pixel H blank, then single-pixel V blank.
    cpu_wr(12'h000, 16'h7FFF, 1'b0, 1'b0);
    hs = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vs = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      pix(15'h0000, hs[i], vs[i]);
      if (i >= 2)
        check($sformatf("blank_px%0d", i), {HBLn_out, VBLn_out, R, G, B},
              {hs[i-2], vs[i-2], ((hs[i-2] && vs[i-2]) ? 24'hFFFFFF : 24'h000000)});
    end

    // Without ce_pixel the outputs hold regardless of inputs.
    pix(15'h0000, 1'b1, 1'b1);
    pix(15'h0000, 1'b1, 1'b1);
    SC = 15'h0003; HBLOn = 1'b0; VBLOn = 1'b0;
    for (int i = 0; i < 6; i++) tick;
    check("ce_hold", {HBLn_out, VBLn_out, R, G, B}, {2'b11, 24'hFFFFFF});

    // Collision: video reads addr 7 in the very clock the CPU writes it.
    cpu_wr(12'h007, 16'h0000, 1'b0, 1'b0);
    pix(15'h0007, 1'b1, 1'b1);
    pix(15'h0007, 1'b1, 1'b1);
    pix(15'h0007, 1'b1, 1'b1);
    check("coll_before", {R, G, B}, 24'h000000);
    VA = 12'h007; Din = 16'h001F; RW = 1'b0; UDSn = 1'b0; LDSn = 1'b0; CSn = 1'b0;
    tick;              // edge detected
    tick;              // write lands, video read sees old word
    ce_pixel = 1'b1;
    tick;              // colour register takes the old word
    ce_pixel = 1'b0;
    check("coll_dack", DACKn, 0);
    cpu_end;
    pix(15'h0007, 1'b1, 1'b1);
    check("coll_old", {R, G, B}, 24'h000000);
    pix(15'h0007, 1'b1, 1'b1);
    check("coll_new", {R, G, B}, 24'h0000FF);

    // CSn held low: DACKn stays low until release.
    cpu_start(12'h005, 16'h0000, 1'b1, 1'b0, 1'b0, lat);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (DACKn === 1'b0) cnt++;
    end
    check("hold_low", cnt, 20);
    check("hold_dout", Dout, 16'h7FFF);
    cpu_end;

    // CSn released during ACCESS: write completes, no DTACK.
    VA = 12'h030; Din = 16'h5A5A; RW = 1'b0; UDSn = 1'b0; LDSn = 1'b0; CSn = 1'b0;
    cnt = 0;
    tick;
    if (DACKn === 1'b1) cnt++;
    CSn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (DACKn === 1'b1) cnt++;
    end
    check("abort_no_dack", cnt, 5);
    cpu_rd(12'h030, q, lat);
    check("abort_write", q, 16'h5A5A);

    // Reset during ACK.
    pix(15'h0005, 1'b1, 1'b1);
    pix(15'h0005, 1'b1, 1'b1);
    pix(15'h0005, 1'b1, 1'b1);
    check("pre_reset_rgb", {R, G, B}, 24'hFFFFFF);
    cpu_start(12'h005, 16'h0000, 1'b1, 1'b0, 1'b0, lat);
    reset = 1'b1;
    tick;
    check("rst_ack_dackn", DACKn, 1);
    check("rst_ack_rgb", {R, G, B}, 24'h000000);
    tick;
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (DACKn === 1'b1) cnt++;
    end
    check("rst_no_dack", cnt, 4);
    CSn = 1'b1;
    tick;
    pix(15'h0005, 1'b1, 1'b1);
    pix(15'h0005, 1'b1, 1'b1);
    pix(15'h0005, 1'b1, 1'b1);
    check("ram_kept", {R, G, B}, 24'hFFFFFF);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/tc0260dar_palette.md
Name: tc0260dar_palette

Overview:
- Palette stage directly downstream of the tilemap generator: consumes the 15-bit colour index (SC) produced each pixel and converts it to 8-bit RGB via an internal palette RAM.
- Provides the 68000-side palette RAM read/write port with DTACK generation.
- Applies H/V blanking and delays the blank strobes so they stay aligned with the RGB output.

Parameters:
- ADDR_WIDTH, 12, palette RAM word-address width (4096 entries).
- RGB_FORMAT, 0, 0 = xRRRRRGGGGGBBBBB (RGB555); 1 = RRRRGGGGBBBBxxxx (RGB444).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ce_pixel  in  1  pixel clock enable
- VA  in  ADDR_WIDTH  CPU word address (VA[ADDR_WIDTH:1])
- Din  in  16  CPU write data
- Dout  out  16  CPU read data
- LDSn  in  1  lower byte strobe
- UDSn  in  1  upper byte strobe
- CSn  in  1  palette chip select
- RW  in  1  1 = read
- DACKn  out  1  data acknowledge, active low
- SC  in  15  colour index from tilemap stage
- HBLOn  in  1  horizontal blank, active low
- VBLOn  in  1  vertical blank, active low
- R, G, B  out  8 each  pixel colour
- HBLn_out, VBLn_out  out  1 each  blanks aligned to RGB

Behaviour:
- Reset values:
  - R = G = B = 0; Dout = 0; DACKn = 1; HBLn_out = VBLn_out = 0.
  - Pipeline registers cleared; CPU FSM goes to IDLE.
  - RAM contents are not cleared.
- Video pipeline (advances only on ce_pixel; otherwise every register holds):
  - P0: latch idx = SC[ADDR_WIDTH-1:0] (upper SC bits ignored) and the blank pair. The RAM video port is read with idx on the following clk.
  - P1: latch RAM word into the colour register; shift blanks.
  - P2: expand the colour word to RGB and drive outputs. Latency is 2 ce_pixel periods from SC sample to R/G/B.
  - Expansion: RGB555 uses 5 bits plus the top 3 bits replicated ({c, c[4:2]}). RGB444 uses 4 bits plus the same 4 bits replicated ({c, c}).
  - If either delayed blank is low, output RGB = 0. HBLn_out/VBLn_out equal the inputs delayed by the same 2 pixel periods.
- CPU FSM states: IDLE, ACCESS, ACK.
  - IDLE: a falling edge of CSn (CSn registered; prev = 1, now = 0) moves to ACCESS and latches VA, Din, LDSn, UDSn, RW.
  - ACCESS, one clk:
    - Write: RAM port B writes enabled byte lanes only (~UDSn → [15:8], ~LDSn → [7:0]). Both strobes high means no write, but DTACK still follows.
    - Read: RAM read issued.
  - ACK: Dout <= RAM data (reads only; writes leave Dout unchanged), DACKn <= 0. Hold until CSn = 1, then DACKn <= 1 and go to IDLE in the same clk.
  - DACKn low 2 clks after the CS edge is detected.
  - CSn rising during ACCESS: the access completes, DACKn stays 1, and the FSM returns to IDLE.
- Simultaneous CPU write and video read of the same address in the same clk: video gets the old data; the new data is visible from the next read.
- CPU access is independent of ce_pixel and never stalls video.
- Reset mid-access: DACKn returns to 1 immediately. A write already in ACCESS may or may not land. No DACK is issued for the aborted cycle.

Decomposition:
- Shared package tc0260dar_pkg holds:
  - localparams for the RGB_FORMAT codes;
  - the cpu_state_t enum (IDLE, ACCESS, ACK);
  - the function expand_rgb(word, format) returning a 24-bit value.
- One sub-module, palette_dpram: true dual-port RAM with synchronous read on both ports and byte enables on port B. It infers block RAM and gives read-before-write behaviour on cross-port collision.

Test Plan:
- CPU write 0x7FFF to addr 5 (RGB555, both strobes), then SC = 5 with blanks high → after 2 ce_pixel, R = G = B = 0xFF. CPU read of addr 5 returns Dout = 0x7FFF with DACKn low 2 clks after the CS edge.
- Byte write: addr 9 holds 0x1234; write Din = 0xAB00 with UDSn = 0, LDSn = 1 → read back 0xAB34.
- RGB444: addr 3 = 0xF80C → R = 0xFF, G = 0x88, B = 0x00.
- Blanking: addr 0 = 0x7FFF, SC = 0, HBLOn = 0 for one pixel → exactly one output pixel is RGB = 0 with HBLn_out = 0, aligned two pixels later.
- Collision: video reads addr 7 (old 0x0000) in the same clk as a CPU write of 0x001F to addr 7 → that pixel B = 0; the next pixel at addr 7 gives B = 0xFF.
- Handshake: hold CSn low 20 clks → DACKn stays low until CSn = 1, then returns to 1 within 1 clk. Assert reset during ACK → DACKn = 1 and RGB = 0 on the next clk.
